// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared defaults and FSM state type for the I2S transmitter
package i2s_pkg;
   localparam int DEF_DATA_W   = 24;
   localparam int DEF_SCLK_DIV = 4;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      SHIFT = 2'd1,
      PAD   = 2'd2
   } i2s_state_e;
endpackage

// File: rtl/i2s_bitclk.sv
// rtl/i2s_bitclk.sv - sclk generator advancing on mclk pulses, realigned by resync
module i2s_bitclk
   import i2s_pkg::*;
#(
   parameter int SCLK_DIV = DEF_SCLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic mclk,
   input  logic run,
   input  logic resync,
   output logic sclk,
   output logic sclk_fall
);
   localparam int TICK_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(SCLK_DIV - 1);

   logic [TICK_W-1:0] tick;
   logic              tick_wrap;

   // resync wins over a coincident mclk pulse so the slot always restarts cleanly
   assign tick_wrap = mclk && run && !resync && (tick == TICK_MAX);
   assign sclk_fall = tick_wrap && sclk;

   always_ff @(posedge clk) begin
      if (rst || resync || !run) begin
         tick <= '0;
         sclk <= 1'b0;
      end else if (mclk) begin
         if (tick == TICK_MAX) begin
            tick <= '0;
            sclk <= ~sclk;
         end else begin
            tick <= tick + TICK_W'(1);
         end
      end
   end
endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S serializer: staging/active sample registers, shifter and framing FSM
// Define I2S_UNDERRUN_REPEAT_EN to repeat the last pair on underrun instead of playing silence.
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int SCLK_DIV = DEF_SCLK_DIV
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mclk,
   input  logic              lrck,
   input  logic [DATA_W-1:0] s_left,
   input  logic [DATA_W-1:0] s_right,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              sclk,
   output logic              sdata,
   output logic              underrun
);
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

   logic                lrck_d;
   logic                lrck_edge;
   logic                fall_edge;
   logic                stage_full;
   logic [2*DATA_W-1:0] stage;
   logic [2*DATA_W-1:0] active;
   logic [2*DATA_W-1:0] active_next;
   logic [DATA_W-1:0]   shift;
   logic [BIT_W-1:0]    bit_cnt;
   logic                sclk_fall;
   logic                load;
   i2s_state_e          state_q;
   i2s_state_e          state_d;

   always_ff @(posedge clk) lrck_d <= lrck;

   assign lrck_edge = (lrck != lrck_d);
   assign fall_edge = lrck_edge && !lrck;
   assign s_ready   = !stage_full;
   assign underrun  = fall_edge && !stage_full && !rst;

   always_comb begin
      active_next = active;
      if (fall_edge) begin
         if (stage_full) begin
            active_next = stage;
         end else begin
`ifdef I2S_UNDERRUN_REPEAT_EN
            active_next = active;
`else
            active_next = '0;
`endif
         end
      end
   end

   // a handshake cannot coincide with a full-staging transfer because s_ready is low
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_full <= 1'b0;
         stage      <= '0;
         active     <= '0;
      end else begin
         active <= active_next;
         if (fall_edge && stage_full) begin
            stage_full <= 1'b0;
         end else if (s_valid && s_ready) begin
            stage      <= {s_left, s_right};
            stage_full <= 1'b1;
         end
      end
   end

   i2s_bitclk #(.SCLK_DIV(SCLK_DIV)) u_bitclk (
      .clk       (clk),
      .rst       (rst),
      .mclk      (mclk),
      .run       (state_q != SYNC),
      .resync    (load),
      .sclk      (sclk),
      .sclk_fall (sclk_fall)
   );

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         SYNC: begin
            if (fall_edge) begin
               state_d = SHIFT;
               load    = 1'b1;
            end
         end
         SHIFT: begin
            if (lrck_edge) begin
               load = 1'b1;
            end else if (sclk_fall && bit_cnt == BIT_LAST) begin
               state_d = PAD;
            end
         end
         PAD: begin
            if (lrck_edge) begin
               state_d = SHIFT;
               load    = 1'b1;
            end
         end
         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SYNC;
         shift   <= '0;
         bit_cnt <= '0;
         sdata   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            shift   <= lrck ? active_next[DATA_W-1:0] : active_next[2*DATA_W-1:DATA_W];
            bit_cnt <= '0;
            sdata   <= 1'b0;
         end else if (state_q == SHIFT && sclk_fall) begin
            if (bit_cnt == BIT_LAST) begin
               sdata <= 1'b0;
            end else begin
               sdata   <= shift[DATA_W-1];
               shift   <= {shift[DATA_W-2:0], 1'b0};
               bit_cnt <= bit_cnt + BIT_W'(1);
            end
         end
      end
   end
endmodule
